ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning program counter and instruction-memory address width.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port imem_req, output, 1, fetch request strobe, one request per cycle when high.
REQ-007 SHALL have port imem_addr, output, PC_W, byte address of the request.
REQ-008 SHALL have port imem_valid, input, 1, response strobe; responses return in order, latency of 1 or more cycles.
REQ-009 SHALL have port imem_rdata, input, INS_W, response instruction.
REQ-010 SHALL have port redirect, input, 1, branch/jump taken, flush.
REQ-011 SHALL have port redirect_pc, input, PC_W, new fetch address.
REQ-012 SHALL have port stall, input, 1, decode not consuming (hazard stall).
REQ-013 SHALL have port out_valid, output, 1, head entry valid.
REQ-014 SHALL have port out_pc, output, PC_W, PC of head instruction.
REQ-015 SHALL have port out_instr, output, INS_W, head instruction.

Function
REQ-016 SHALL hold fetch_pc, resp_pc, count (0..DEPTH), outstanding (0..DEPTH) and drop (0..DEPTH).
REQ-017 SHALL assert imem_req, with imem_addr = fetch_pc, when all three hold: reset low, redirect low, and count + outstanding < DEPTH; a pop in the same cycle does not count.
REQ-018 SHALL advance fetch_pc by 4 on each issued request, modulo 2^PC_W, so 0x1FC wraps to 0x000.
REQ-019 SHALL push {resp_pc, imem_rdata} on each non-dropped imem_valid, then advance resp_pc by 4 modulo 2^PC_W.
REQ-020 SHALL drive out_valid = (count != 0), with out_pc/out_instr taken from the head entry.
REQ-021 SHALL pop the head when out_valid is high and stall is low.
REQ-022 SHALL allow push and pop in the same cycle, leaving count unchanged; it SHALL never overflow or underflow.
REQ-023 SHALL increment outstanding on each request and decrement it on each imem_valid, dropped or not.
REQ-024 SHALL, on redirect, in the same edge:
  - empty the queue (count=0);
  - set fetch_pc = resp_pc = redirect_pc;
  - set drop = outstanding;
  - count any imem_valid in that cycle as dropped.
REQ-025 SHALL, while drop != 0, discard each imem_valid (no push) and decrement drop.
REQ-026 SHALL give redirect priority over stall and over any pop; the first request to redirect_pc issues the cycle after redirect.
REQ-027 SHALL give imem_rdata no defined meaning when imem_valid is low; it SHALL never be captured then.

Reset
REQ-028 SHALL, while reset is high, force:
  - fetch_pc=0, resp_pc=0;
  - count=0, outstanding=0, drop=0;
  - imem_req=0, out_valid=0.
REQ-029 SHALL issue the first request (imem_addr=0) in the first cycle after reset deasserts.
REQ-030 SHALL, on reset mid-operation, discard in-flight responses arriving after reset; the memory is reset concurrently.

Configuration
REQ-031 SHALL, with IFQ_BYPASS_EN defined, present a non-dropped imem_valid response directly on out_valid/out_pc/out_instr in the same cycle when count==0; it is not written to the queue if stall is low and is pushed if stall is high.
REQ-032 SHALL, with IFQ_BYPASS_EN undefined, drive out_* only from registered queue storage, so a response appears one cycle after imem_valid.

Verification
REQ-033 SHALL cover: reset release, 1-cycle memory, stall=0 -> imem_addr 0x000,0x004,0x008…; out_pc 0x000,0x004… one per cycle; first out_valid 2 cycles after first imem_req (no bypass).
REQ-034 SHALL cover: stall held 12 cycles -> imem_req deasserts once count+outstanding=4; count=4; on release out_pc 0x000,0x004,0x008,0x00C in 4 consecutive cycles, none lost.
REQ-035 SHALL cover: 3-cycle memory latency, redirect to 0x100 with 2 requests outstanding -> both responses discarded; next out_pc=0x100 with the instruction stored at 0x100.
REQ-036 SHALL cover: redirect to 0x1FC -> out_pc 0x1FC then 0x000.
REQ-037 SHALL cover: redirect, stall and imem_valid in the same cycle -> next cycle out_valid=0, that response never appears.
REQ-038 SHALL cover, with IFQ_BYPASS_EN: queue empty, imem_valid with rdata 0x00500093, stall=0 -> out_valid=1 and out_instr=0x00500093 in that same cycle; count stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses
// and flushes on redirect. Define IFQ_BYPASS_EN to forward responses to an empty queue.
module ifetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             stall,
    output logic             out_valid,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: the memory accepts every cycle imem_req is high and returns exactly
    // one imem_valid per request, in order; decode takes the head whenever out_valid
    // is high and stall is low.

    logic [PC_W-1:0]  fetch_pc, resp_pc;
    logic [CW-1:0]    count, outstanding, drop;
    logic [AW-1:0]    head, tail;
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];

    logic [CW:0] occupancy;
    logic        resp_ok, accept, q_valid, pop, write;

    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    // A strobe with nothing outstanding cannot belong to us (e.g. straddling reset).
    assign resp_ok = imem_valid && (outstanding != '0) && !reset;
    assign accept  = resp_ok && (drop == '0) && !redirect;
    assign q_valid = (count != '0);
    assign pop     = q_valid && !stall && !redirect;

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass    = accept && !q_valid;
    assign write     = accept && !(bypass && !stall);
    assign out_valid = !reset && (q_valid || bypass);
    assign out_pc    = q_valid ? pc_mem[head]  : resp_pc;
    assign out_instr = q_valid ? ins_mem[head] : imem_rdata;
`else
    assign write     = accept;
    assign out_valid = !reset && q_valid;
    assign out_pc    = pc_mem[head];
    assign out_instr = ins_mem[head];
`endif

    always_ff @(posedge clk) begin
        if (write) begin
            pc_mem[tail]  <= resp_pc;
            ins_mem[tail] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            resp_pc     <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= outstanding + CW'(imem_req) - CW'(resp_ok);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                // A response arriving in the redirect cycle is already discarded here.
                drop     <= outstanding - CW'(resp_ok);
            end else begin
                if (imem_req) fetch_pc <= fetch_pc + PC_W'(4);
                if (accept)   resp_pc  <= resp_pc + PC_W'(4);
                if (write)    tail     <= tail + AW'(1);
                if (pop)      head     <= head + AW'(1);
                count <= count + CW'(write) - CW'(pop);
                if (resp_ok && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a latency-configurable in-order memory model,
// a stall table, and hand-written redirect sequences.
module tb_ifetch_queue;
    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;

`ifdef IFQ_BYPASS_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 2;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [8:0] addr;
        int         due;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic       stall;
        logic       req;
        logic [8:0] addr;
        logic       vld;
        logic [8:0] pc;
    } vec_t;
    vec_t tbl[18];

    ifetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        if (a == 9'h0C0) return 32'h0050_0093;
        return {16'hC0DE, 7'h0, a};
    endfunction

    // In-order memory: a request seen in cycle k answers in cycle k+lat.
    always @(negedge clk) begin
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (reset) begin
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
            if (imem_req) pend.push_back('{imem_addr, cyc + lat});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_head(input string name, input logic [8:0] pc);
        chk({name, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_pc"}, {23'd0, out_pc}, {23'd0, pc});
        chk({name, "_ins"}, out_instr, mem_word(pc));
    endtask

    task automatic chk_req(input string name, input logic [8:0] addr);
        chk({name, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({name, "_addr"}, {23'd0, imem_addr}, {23'd0, addr});
    endtask

    task automatic do_reset(input int l);
        lat = l;
        reset = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        repeat (3) begin
            next_cycle();
            sample();
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_vld", {31'd0, out_valid}, 32'd0);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [8:0] a,
                                input logic v, input logic [8:0] p);
        vec_t t;
        t.stall = s; t.req = r; t.addr = a; t.vld = v; t.pc = p;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;

        // Stall held from reset release for 12 cycles, then released.
        tbl[0] = mk(1, 1, 9'h000, 0, 9'h000);
`ifdef IFQ_BYPASS_EN
        tbl[1] = mk(1, 1, 9'h004, 1, 9'h000);
`else
        tbl[1] = mk(1, 1, 9'h004, 0, 9'h000);
`endif
        tbl[2] = mk(1, 1, 9'h008, 1, 9'h000);
        tbl[3] = mk(1, 1, 9'h00C, 1, 9'h000);
        for (int i = 4; i < 12; i++) tbl[i] = mk(1, 0, 9'h000, 1, 9'h000);
        tbl[12] = mk(0, 0, 9'h000, 1, 9'h000);
        for (int i = 13; i < 18; i++)
            tbl[i] = mk(0, 1, 9'((i - 9) * 4), 1, 9'((i - 12) * 4));

        // Free-running 1-cycle memory after reset release.
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            sample();
            chk_req("stream", 9'(4 * k));
            if (k >= LAG) chk_head("stream", 9'(4 * (k - LAG)));
            else chk("stream_idle", {31'd0, out_valid}, 32'd0);
        end

        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            if (i > 0) next_cycle();
            stall = tbl[i].stall;
            sample();
            chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), {23'd0, imem_addr}, {23'd0, tbl[i].addr});
            if (tbl[i].vld) chk_head($sformatf("tbl%0d", i), tbl[i].pc);
            else chk($sformatf("tbl%0d_vld", i), {31'd0, out_valid}, 32'd0);
        end

        // Redirect, stall and a response all in one cycle.
        next_cycle();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 9'h080;
        sample();
        chk("rsv_req", {31'd0, imem_req}, 32'd0);
        chk("rsv_resp_present", {31'd0, imem_valid}, 32'd1);
        next_cycle();
        redirect = 1'b0; stall = 1'b0;
        sample();
        chk("rsv_flush_vld", {31'd0, out_valid}, 32'd0);
        chk_req("rsv", 9'h080);
        for (int j = 2; j < 1 + LAG; j++) begin
            next_cycle(); sample();
            chk("rsv_wait_vld", {31'd0, out_valid}, 32'd0);
        end
        next_cycle(); sample();
        chk_head("rsv_first", 9'h080);
        next_cycle(); sample();
        chk_head("rsv_second", 9'h084);

        // Redirect near the top of the address space: fetch and output wrap.
        next_cycle();
        redirect = 1'b1; redirect_pc = 9'h1FC;
        sample();
        chk("wrap_redir_req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        chk_req("wrap_first", 9'h1FC);
        chk("wrap_flush_vld", {31'd0, out_valid}, 32'd0);
        next_cycle(); sample();
        chk_req("wrap_second", 9'h000);
        exp_q = {9'h1FC, 9'h000, 9'h004};
        for (int b = 0; b < 10 && exp_q.size() > 0; b++) begin
            if (b > 0) begin next_cycle(); sample(); end
            if (out_valid) chk_head("wrap_out", exp_q.pop_front());
        end
        chk("wrap_drained", exp_q.size(), 32'd0);

        // Response into an empty queue: forwarded same cycle with bypass, else next cycle.
        next_cycle();
        redirect = 1'b1; redirect_pc = 9'h0C0;
        sample();
        next_cycle();
        redirect = 1'b0;
        sample();
        chk_req("byp", 9'h0C0);
        for (int j = 2; j < 1 + LAG; j++) begin
            next_cycle(); sample();
            chk("byp_wait_vld", {31'd0, out_valid}, 32'd0);
        end
        next_cycle(); sample();
`ifdef IFQ_BYPASS_EN
        chk("byp_same_cycle_resp", {31'd0, imem_valid}, 32'd1);
`endif
        chk_head("byp_first", 9'h0C0);
        chk("byp_instr", out_instr, 32'h0050_0093);
        next_cycle(); sample();
        chk_head("byp_second", 9'h0C4);
        chk("byp_req_cont", {31'd0, imem_req}, 32'd1);

        // 3-cycle memory: redirect with two requests outstanding.
        do_reset(3);
        sample();
        chk_req("lat3_r0", 9'h000);
        next_cycle(); sample();
        chk_req("lat3_r1", 9'h004);
        next_cycle();
        redirect = 1'b1; redirect_pc = 9'h100;
        sample();
        chk("lat3_redir_req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        chk_req("lat3_new", 9'h100);
        chk("lat3_vld3", {31'd0, out_valid}, 32'd0);
        for (int j = 4; j < 5 + LAG; j++) begin
            next_cycle(); sample();
            chk($sformatf("lat3_vld%0d", j), {31'd0, out_valid}, 32'd0);
        end
        next_cycle(); sample();
        chk_head("lat3_first", 9'h100);
        next_cycle(); sample();
        chk_head("lat3_second", 9'h104);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
